// File: rtl/mc_speed_pi.sv
// Speed-loop PI controller: averaged speed sample in, clamped PWM duty word out.
// Five-state pipeline (IDLE/ERR/MUL/ACC/OUT) with a saturating integrator.
module mc_speed_pi #(
    parameter int FRAC_BITS = 8,
    parameter int DUTY_W    = 11,
    parameter int DUTY_MAX  = 2000,
    parameter int INT_LIMIT = DUTY_MAX << FRAC_BITS
) (
    input  logic              up_clk,
    input  logic              up_rstn,
    input  logic              enable_i,
    input  logic [31:0]       ref_speed_i,
    input  logic [15:0]       kp_i,
    input  logic [15:0]       ki_i,
    input  logic [31:0]       speed_i,
    input  logic              speed_valid_i,
    output logic [DUTY_W-1:0] duty_o,
    output logic              duty_valid_o,
    output logic              busy_o,
    output logic              integ_sat_o,
    output logic [15:0]       drop_count_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_MUL,
        S_ACC,
        S_OUT
    } state_t;

    localparam logic signed [50:0] LIM_P = 51'(INT_LIMIT);
    localparam logic signed [50:0] LIM_N = -LIM_P;
    localparam logic signed [50:0] DMAX  = 51'(DUTY_MAX);

    state_t state;

    logic [31:0] ref_q;
    logic [31:0] speed_q;
    logic [15:0] kp_q;
    logic [15:0] ki_q;

    logic signed [32:0] err_q;
    logic signed [49:0] p_q;
    logic signed [49:0] iinc_q;
    logic signed [49:0] integ_q;

    logic [DUTY_W-1:0] duty_q;
    logic              duty_valid_q;
    logic              sat_q;
    logic [15:0]       drop_q;

    logic signed [32:0] err_c;
    logic signed [49:0] kp_ext;
    logic signed [49:0] ki_ext;
    logic signed [49:0] err_ext;
    logic signed [49:0] p_c;
    logic signed [49:0] iinc_c;
    logic signed [50:0] isum;
    logic signed [49:0] integ_nx;
    logic               sat_nx;
    logic signed [50:0] osum;
    logic signed [50:0] y;
    logic [DUTY_W-1:0]  duty_nx;
    logic               drop_hit;

    // Error is formed on 33 bits so the unsigned difference cannot overflow.
    assign err_c   = {1'b0, ref_q} - {1'b0, speed_q};

    // Gains are unsigned, so they enter the signed product zero-extended.
    assign kp_ext  = {{34{1'b0}}, kp_q};
    assign ki_ext  = {{34{1'b0}}, ki_q};
    assign err_ext = {{17{err_q[32]}}, err_q};
    assign p_c     = kp_ext * err_ext;
    assign iinc_c  = ki_ext * err_ext;

    // One guard bit on the integrator sum so the clamp sees the true value.
    assign isum     = {integ_q[49], integ_q} + {iinc_q[49], iinc_q};
    assign integ_nx = (isum > LIM_P) ? LIM_P[49:0] :
                      (isum < LIM_N) ? LIM_N[49:0] :
                      isum[49:0];
    assign sat_nx   = (isum >= LIM_P) || (isum <= LIM_N);

    // Output stage uses the freshly clamped integrator so duty lands in OUT.
    assign osum    = {p_q[49], p_q} + {integ_nx[49], integ_nx};
    assign y       = osum >>> FRAC_BITS;
    assign duty_nx = y[50]      ? '0 :
                     (y > DMAX) ? DMAX[DUTY_W-1:0] :
                     y[DUTY_W-1:0];

    assign drop_hit = enable_i && speed_valid_i && (state != S_IDLE);

    // Sequencer plus all datapath registers; disable aborts and clears the loop.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            state        <= S_IDLE;
            ref_q        <= '0;
            speed_q      <= '0;
            kp_q         <= '0;
            ki_q         <= '0;
            err_q        <= '0;
            p_q          <= '0;
            iinc_q       <= '0;
            integ_q      <= '0;
            duty_q       <= '0;
            duty_valid_q <= 1'b0;
            sat_q        <= 1'b0;
        end else if (!enable_i) begin
            state        <= S_IDLE;
            integ_q      <= '0;
            sat_q        <= 1'b0;
            duty_q       <= '0;
            duty_valid_q <= 1'b0;
        end else begin
            duty_valid_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (speed_valid_i) begin
                        ref_q   <= ref_speed_i;
                        speed_q <= speed_i;
                        kp_q    <= kp_i;
                        ki_q    <= ki_i;
                        state   <= S_ERR;
                    end
                end
                S_ERR: begin
                    err_q <= err_c;
                    state <= S_MUL;
                end
                S_MUL: begin
                    p_q    <= p_c;
                    iinc_q <= iinc_c;
                    state  <= S_ACC;
                end
                S_ACC: begin
                    integ_q      <= integ_nx;
                    sat_q        <= sat_nx;
                    duty_q       <= duty_nx;
                    duty_valid_q <= 1'b1;
                    state        <= S_OUT;
                end
                S_OUT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Count samples arriving while a calculation is in flight; sticks at max.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            drop_q <= '0;
        end else if (drop_hit && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign duty_o       = duty_q;
    assign duty_valid_o = duty_valid_q;
    assign busy_o       = (state != S_IDLE);
    assign integ_sat_o  = sat_q;
    assign drop_count_o = drop_q;

endmodule
